// File: rtl/fsm_div.sv
// ---------------------------------------------------------------------------
// fsm_div : sequential R = a / b - c - d
//
// Four unsigned operands (a, b, c, d) arrive one per valid_in strobe on d_in.
// The block divides a by b using restoring division, one quotient bit per
// cycle, and then subtracts c and d. The signed result or a zero-operand
// error (a==0 or b==0) is reported with a one-cycle valid_out pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   valid_in   in   operand strobe, d_in captured on each edge where it is 1
//   d_in       in   [DATA_W-1:0] operand bus, order a, b, c, d (unsigned)
//   valid_out  out  one-cycle pulse: d_out / error_out valid from here on
//   d_out      out  [DATA_W-1:0] result, two's complement
//   error_out  out  1 = a==0 or b==0 (d_out forced to 0)
//   dbg_state  out  [2:0] current FSM state, for observation only
//
// Handshake: there is no back-pressure. valid_in is honoured only in IDLE,
// GET_B, GET_C and GET_D and ignored in every other state (nothing queued).
// valid_out is high for exactly the one cycle spent in DONE; d_out and
// error_out then hold until the next DONE or reset.
//
// Optional feature, macro FSM_DIV_SAT_EN: when defined, the result is
// saturated to the signed DATA_W range instead of wrapping.
//
// Latency: valid_out rises DATA_W+3 edges after the edge capturing d. DIV
// spends one load cycle (copy a into the working dividend, clear the partial
// remainder) followed by DATA_W iteration cycles.
// ---------------------------------------------------------------------------
module fsm_div #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] d_in,
   output logic              valid_out,
   output logic [DATA_W-1:0] d_out,
   output logic              error_out,
   output logic [2:0]        dbg_state
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int ACC_W = DATA_W + 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GET_B = 3'd1,
      GET_C = 3'd2,
      GET_D = 3'd3,
      DIV   = 3'd4,
      SUB_C = 3'd5,
      SUB_D = 3'd6,
      DONE  = 3'd7
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] a_q, b_q, c_q, d_q;
   logic [DATA_W-1:0] quo_q;      // shifting dividend, becomes the quotient
   logic [DATA_W-1:0] rem_q;      // partial remainder, always < b
   logic [CNT_W-1:0]  cnt_q;
   logic              err_q;
   logic [ACC_W-1:0]  acc_q;      // signed accumulator, cannot overflow
   logic              valid_out_q;
   logic [DATA_W-1:0] d_out_q;
   logic              error_out_q;

   // Combinational next values for one division step and the final result.
   logic [DATA_W:0]   trial_d;
   logic [DATA_W:0]   trial_sub_d;
   logic              quo_bit_d;
   logic [DATA_W-1:0] rem_d;
   logic [ACC_W-1:0]  acc_fin_d;
   logic [DATA_W-1:0] res_d;

   always_comb begin
      trial_d     = {rem_q, quo_q[DATA_W-1]};
      trial_sub_d = trial_d - {1'b0, b_q};
      quo_bit_d   = (trial_d >= {1'b0, b_q});
      rem_d       = quo_bit_d ? trial_sub_d[DATA_W-1:0] : trial_d[DATA_W-1:0];
      acc_fin_d   = acc_q - {2'b00, d_q};
`ifdef FSM_DIV_SAT_EN
      // In range exactly when the three top bits agree (sign extension).
      if ((acc_fin_d[ACC_W-1:DATA_W-1] == 3'b000) ||
          (acc_fin_d[ACC_W-1:DATA_W-1] == 3'b111)) begin
         res_d = acc_fin_d[DATA_W-1:0];
      end else if (acc_fin_d[ACC_W-1]) begin
         res_d = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         res_d = {1'b0, {(DATA_W-1){1'b1}}};
      end
`else
      res_d = acc_fin_d[DATA_W-1:0];
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         d_q         <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         acc_q       <= '0;
         valid_out_q <= 1'b0;
         d_out_q     <= '0;
         error_out_q <= 1'b0;
      end else begin
         valid_out_q <= 1'b0;
         case (state)
            IDLE: if (valid_in) begin
               a_q         <= d_in;
               error_out_q <= 1'b0;
               state       <= GET_B;
            end
            GET_B: if (valid_in) begin
               b_q   <= d_in;
               state <= GET_C;
            end
            GET_C: if (valid_in) begin
               c_q   <= d_in;
               state <= GET_D;
            end
            GET_D: if (valid_in) begin
               d_q   <= d_in;
               err_q <= (a_q == '0) || (b_q == '0);
               cnt_q <= '0;
               state <= DIV;
            end
            DIV: begin
               if (cnt_q == '0) begin
                  quo_q <= a_q;
                  rem_q <= '0;
               end else begin
                  quo_q <= {quo_q[DATA_W-2:0], quo_bit_d};
                  rem_q <= rem_d;
               end
               if (cnt_q == CNT_W'(DATA_W)) begin
                  cnt_q <= '0;
                  state <= SUB_C;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            SUB_C: begin
               // On error the quotient counts as zero.
               acc_q <= (err_q ? {ACC_W{1'b0}} : {2'b00, quo_q}) - {2'b00, c_q};
               state <= SUB_D;
            end
            SUB_D: begin
               acc_q       <= acc_fin_d;
               d_out_q     <= err_q ? '0 : res_d;
               error_out_q <= err_q;
               valid_out_q <= 1'b1;
               state       <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign valid_out = valid_out_q;
   assign d_out     = d_out_q;
   assign error_out = error_out_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_fsm_div.sv
// ---------------------------------------------------------------------------
// tb_fsm_div : self-checking bench for fsm_div (DATA_W = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fsm_div;

  localparam int DATA_W = 4;
  localparam int EXP_W  = DATA_W + 1;   // {error, d_out}
  localparam int LAT    = DATA_W + 3;
  localparam int SMAX   = (1 << (DATA_W - 1)) - 1;
  localparam int SMIN   = -(1 << (DATA_W - 1));

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              valid_in = 1'b0;
  logic [DATA_W-1:0] d_in = '0;
  logic              valid_out;
  logic [DATA_W-1:0] d_out;
  logic              error_out;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  fsm_div #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .d_in      (d_in),
    .valid_out (valid_out),
    .d_out     (d_out),
    .error_out (error_out),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;

  always @(negedge clk) if (valid_out) pulse_cnt++;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] model(input int a, input int b, input int c, input int d);
    int r;
    if (a == 0 || b == 0) return {1'b1, {DATA_W{1'b0}}};
    r = a / b - c - d;
`ifdef FSM_DIV_SAT_EN
    if (r > SMAX) r = SMAX;
    if (r < SMIN) r = SMIN;
`endif
    return {1'b0, r[DATA_W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Drives a, b, c, d with random idle gaps (max_gap=0 gives back-to-back).
  task automatic send_ops(input int a, input int b, input int c, input int d, input int max_gap);
    int ops[4];
    ops = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = (i == 0) ? 0 : int'($urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        valid_in = 1'b0;
        d_in = DATA_W'($urandom_range(0, 15));
      end
      @(negedge clk);
      valid_in = 1'b1;
      d_in = DATA_W'(ops[i]);
    end
    @(negedge clk);   // first falling edge after the edge capturing d
    valid_in = 1'b0;
  endtask

  // Waits for the result, pops the scoreboard and checks latency, pulse
  // width and output hold. junk=1 keeps valid_in high with random data for
  // the first cycles of DIV, which must be ignored.
  task automatic wait_result(input string tag, input bit junk);
    logic [EXP_W-1:0] exp;
    int k;
    k = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (valid_out) begin
        k = n;
        break;
      end
      valid_in = junk && (n <= 3);
      d_in = DATA_W'($urandom_range(0, 15));
    end
    valid_in = 1'b0;
    if (k == 0) begin
      check({tag, "_timeout"}, 8'd0, 8'd1);
      return;
    end
    exp_pulses++;
    check({tag, "_latency"}, 8'(k), 8'(LAT));
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 8'd1, 8'd0);
      return;
    end
    exp = exp_q.pop_front();
    check({tag, "_err"}, 8'(error_out), 8'(exp[DATA_W]));
    check({tag, "_dout"}, 8'(d_out), 8'(exp[DATA_W-1:0]));
    @(negedge clk);
    check({tag, "_pulse_end"}, 8'(valid_out), 8'd0);
    check({tag, "_state_idle"}, 8'(dbg_state), 8'd0);
    check({tag, "_dout_hold"}, 8'(d_out), 8'(exp[DATA_W-1:0]));
    check({tag, "_err_hold"}, 8'(error_out), 8'(exp[DATA_W]));
  endtask

  task automatic run_txn(input string tag, input int a, input int b, input int c,
                         input int d, input int max_gap, input bit junk);
    exp_q.push_back(model(a, b, c, d));
    send_ops(a, b, c, d, max_gap);
    wait_result(tag, junk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("rst_valid", 8'(valid_out), 8'd0);
    check("rst_dout", 8'(d_out), 8'd0);
    check("rst_err", 8'(error_out), 8'd0);
    check("rst_state", 8'(dbg_state), 8'd0);
    reset = 1'b1;
    @(negedge clk);

    run_txn("b_zero",   5, 0,  1,  2, 2, 1'b0);
    run_txn("a_zero",   0, 4,  3,  2, 0, 1'b0);
    run_txn("ab_zero",  0, 0,  1,  2, 1, 1'b0);
    run_txn("neg3",     8, 2,  5,  2, 0, 1'b1);
    run_txn("trunc",    9, 2,  1,  3, 2, 1'b0);
    // error_out must clear once a new a is captured
    run_txn("wrap",     1, 1, 15, 15, 0, 1'b1);

    // abort in DIV: reset mid-computation, no pulse expected
    send_ops(7, 1, 0, 0, 0);
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (dbg_state == 3'd4) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_in_div", 8'(seen), 8'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_state", 8'(dbg_state), 8'd0);
    check("abort_valid", 8'(valid_out), 8'd0);
    check("abort_dout", 8'(d_out), 8'd0);
    check("abort_err", 8'(error_out), 8'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_pulse", 8'(pulse_cnt), 8'(exp_pulses));
    check("abort_dout_idle", 8'(d_out), 8'd0);

    run_txn("after_abort", 6, 3, 1, 0, 1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int a, b, c, d;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      c = int'($urandom_range(0, 15));
      d = int'($urandom_range(0, 15));
      run_txn($sformatf("rnd%0d", i), a, b, c, d, 2, i[0]);
    end

    // ---------------- final report ----------------
    repeat (3) @(negedge clk);
    check("sb_empty", 8'(exp_q.size()), 8'd0);
    check("pulse_total", 8'(pulse_cnt), 8'(exp_pulses));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
